mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port and the data (LD/ST) port.
- Sequences each transaction through grant, access, latency wait and response.
- Round-robin arbitration.
- Sits between the multi-cycle control unit's FETCH/MEM_ACCESS requests and the unified memory.

Parameters:
- AW, 8, address width (bits).
- DW, 16, data width (bits).
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch grant pulse.
- if_rvalid  out  1  fetch data-valid pulse.
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data grant pulse.
- d_rvalid  out  1  data completion pulse, for loads and stores.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clk, reset asynchronous active-high.
  - State goes to IDLE.
  - Every output is 0, including if_rdata and d_rdata.
  - last_gnt = DATA, so fetch wins the first contested grant.
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. Grants are issued only in IDLE.
- IDLE:
  - If any request is pending, assert the winner's gnt combinationally in the same cycle (Mealy).
  - At that clock edge, latch the winner id, address, we and wdata. Fetch we is forced to 0.
  - Go to ACCESS. With no request, stay in IDLE with no gnt.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the port that is not last_gnt.
  - last_gnt updates on every grant.
- ACCESS (1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Load counter with MEM_LAT-1; go to WAIT.
  - mem_en, mem_we, mem_addr and mem_wdata are 0 outside ACCESS.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 0 (the MEM_LAT-th cycle after ACCESS), capture mem_rdata into the winner's rdata register if the access was a read; go to RESP.
  - Stores take the identical timing.
- RESP (1 cycle):
  - Winner's rvalid=1; go to IDLE.
  - For a store, d_rvalid pulses and d_rdata keeps its previous value.
- Latency:
  - Grant in cycle T, mem_en in T+1, rvalid in T+2+MEM_LAT.
  - Next grant no earlier than T+3+MEM_LAT.
- Output hold: rdata registers hold their value until the next read completion on the same port.
- Requester rule:
  - Requester must hold req and its address/data stable until gnt.
  - Requester may drop req the cycle after gnt.
  - req still high in the next IDLE counts as a new request.
- gnt is never asserted while busy=1. if_gnt and d_gnt are never high together.
- Reset mid-operation:
  - The in-flight transaction is dropped.
  - No rvalid is produced.
  - The next request after reset release is served normally.
- The counter is 4 bits wide; MEM_LAT outside 1..15 is a configuration error.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: fixed priority; the data port always wins a contested grant. last_gnt is unused.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Reset: hold reset 3 cycles with requests active -> all outputs 0, busy=0, no gnt; release -> first contested grant goes to fetch.
- Single fetch read, MEM_LAT=1: if_req with if_addr=0x10, memory model returns 0xBEEF -> if_gnt in T, mem_en=1/mem_we=0/mem_addr=0x10 in T+1, if_rvalid=1 with if_rdata=0xBEEF in T+3.
- Contention: if_req and d_req held continuously from reset release -> grant order IF, D, IF, D; each rvalid goes to the matching port; gnts never overlap.
- Data store: d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 in the ACCESS cycle; d_rvalid pulses; d_rdata unchanged; a following load of 0x20 returns 0x1234.
- Latency sweep: MEM_LAT=3, fetch read -> rvalid exactly at T+5; busy high T+1..T+5; no grant before T+6.
- Reset in WAIT (MEM_LAT=3) -> no rvalid, busy=0 immediately; new d_req load afterward completes with correct data. With ARB_FIXED_PRIO_EN defined, contested requests always grant D first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// CPU-side request/response ports plus the unified-memory port of mem_port_arbiter.
// slave = the arbiter; master = the requesters and memory facing it.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports: IDLE->ACCESS->WAIT->RESP, round-robin.
// Grant is Mealy in IDLE; rvalid at T+2+MEM_LAT. Define ARB_FIXED_PRIO_EN for fixed data-port priority.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus,
    output logic                  busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          win_d_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    logic          last_d_q;
`endif

    logic          grant_if;
    logic          grant_d;
    logic          capture;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Gated by reset so that no grant leaks out while reset is held.
                if (!reset) begin
                    if (bus.if_req && bus.d_req) begin
`ifdef ARB_FIXED_PRIO_EN
                        grant_d  = 1'b1;
`else
                        grant_if = last_d_q;
                        grant_d  = !last_d_q;
`endif
                    end else begin
                        grant_if = bus.if_req;
                        grant_d  = bus.d_req;
                    end
                end
                if (grant_if || grant_d) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture = !we_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            win_d_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_d_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_if || grant_d) begin
                win_d_q <= grant_d;
                we_q    <= grant_d && bus.d_we;
                addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                wdata_q <= grant_d ? bus.d_wdata : '0;
`ifndef ARB_FIXED_PRIO_EN
                last_d_q <= grant_d;
`endif
            end
            if (capture && !win_d_q) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (capture && win_d_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    logic in_access;
    logic in_resp;
    assign in_access = (state_q == S_ACCESS);
    assign in_resp   = (state_q == S_RESP);

    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = in_resp && !win_d_q;
    assign bus.d_rvalid  = in_resp && win_d_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && we_q;
    assign bus.mem_addr  = in_access ? addr_q : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;

    assign busy = (state_q != S_IDLE);

endmodule
